dct_stream_fifo: RTL and testbench
==================================

# dct_stream_fifo

Parametrised synchronous FIFO for buffering DCT coefficient words between the 1D row-transform, transpose and column-transform stages of the 2D DCT datapath. It generalises the fixed 36-bit × 4 coefficient buffer in the following ways:
- configurable width and depth;
- correct full/empty/count tracking under simultaneous read and write;
- programmable almost-full and almost-empty thresholds;
- optional first-word-fall-through (FWFT) output;
- sticky overflow/underflow error flags;
- synchronous flush.

## Interface
Parameters:
- WIDTH, 36: data word width in bits.
- DEPTH, 8: number of entries; must be a power of two, ≥ 2.
- AF_LEVEL, DEPTH-1: almost_full asserts when count ≥ AF_LEVEL.
- AE_LEVEL, 1: almost_empty asserts when count ≤ AE_LEVEL.
- FWFT, 0: 0 = registered-read mode; 1 = first-word-fall-through mode.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- clr  in  1  synchronous flush; empties the FIFO and clears the error flags.
- wr_en  in  1  write request.
- din  in  WIDTH  write data.
- rd_en  in  1  read request (FWFT=0) or head acknowledge (FWFT=1).
- dout  out  WIDTH  read data.
- dout_valid  out  1  dout holds a valid word.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- almost_full  out  1  count ≥ AF_LEVEL.
- almost_empty  out  1  count ≤ AE_LEVEL.
- count  out  $clog2(DEPTH+1)  current occupancy.
- overflow  out  1  sticky; a write was rejected.
- underflow  out  1  sticky; a read was rejected.

## Operation
Reset (rst=1) sets:
- wr_ptr, rd_ptr and count to 0;
- empty=1, almost_empty=1;
- full=0, almost_full=0;
- dout=0, dout_valid=0;
- overflow=0, underflow=0.

Memory contents are not reset.

Pointers are $clog2(DEPTH) bits and wrap naturally from DEPTH-1 to 0.

Write and read acceptance:
- Write accepted: wr_acc = wr_en & (!full | rd_acc).
- Read accepted: rd_acc = rd_en & !empty.
- A write to a full FIFO succeeds only when paired with an accepted read in the same cycle.
- A read from an empty FIFO never succeeds, even with a simultaneous write.

Count update: count_next = count + wr_acc − rd_acc. Simultaneous accepted read and write leave count unchanged. Count never exceeds DEPTH and never goes below 0.

Flag behaviour:
- full, empty, almost_full and almost_empty are registered from count_next, so they are always consistent with count in the same cycle (no one-cycle lag).
- overflow is set by wr_en & !wr_acc.
- underflow is set by rd_en & !rd_acc.
- Both stay set until clr or rst.

Flush: clr=1 takes priority over wr_en and rd_en in that cycle. It applies the reset values to pointers, count, flags, dout_valid and the error flags. dout keeps its last value.

FWFT=0 (registered read):
- On rd_acc, dout ← mem[rd_ptr] and dout_valid=1 for one cycle.
- Otherwise dout holds its value and dout_valid=0.

FWFT=1:
- dout = mem[rd_ptr] continuously; dout_valid = !empty.
- rd_acc pops the head.
- When empty, dout is undefined and must not be consumed.

Write data is never forwarded to the read side in the same cycle.

## Timing
- FWFT=0:
  - Write at edge N → empty=0 after edge N.
  - rd_en in cycle N+1 → dout and dout_valid after edge N+2.
  - Read latency is 1 cycle from rd_en.
- FWFT=1:
  - Write at edge N → dout_valid=1 and dout = written word after edge N.
- Full throughput: 1 write + 1 read per cycle, sustained at any occupancy from 1 to DEPTH.
- All flag and count outputs update on the same edge as the pointer change that causes them.
- rst asserted mid-operation clears everything immediately (asynchronously). The first accepted write after release lands at address 0.

## Structure
- The shared package dct_pkg holds:
  - DCT_COEF_W = 36 (default WIDTH);
  - DCT_FIFO_DEPTH = 8;
  - the pointer/count width helper function.
- One sub-module, dct_fifo_ram:
  - DEPTH × WIDTH array;
  - synchronous write;
  - asynchronous read port (required by FWFT mode);
  - no reset on the array.
- Pointer, count, flag and output-register logic lives in dct_stream_fifo itself.

## Test plan
Run every scenario with FWFT=0 and with FWFT=1.

1. Reset then idle:
   - Stimulus: hold rst=1, then release.
   - Response: empty=1, almost_empty=1, count=0, full=0, dout_valid=0, overflow=0, underflow=0.
2. Fill to full plus one (DEPTH=8):
   - Stimulus: write 0x1..0x9.
   - Response: full=1 after the 8th write; almost_full=1 from count=7; the 9th write is dropped; overflow=1; count stays 8.
   - Then read 8 words.
   - Response: 0x1..0x8 in order; empty=1; a further rd_en sets underflow=1.
3. Simultaneous read and write at full:
   - Stimulus: with count=8, assert wr_en and rd_en for 4 cycles.
   - Response: count stays 8, overflow stays 0, the oldest 4 words come out in order, and the new words are appended.
4. Simultaneous read and write at empty:
   - Stimulus: with count=0, assert wr_en and rd_en together.
   - Response: the write is accepted, count=1, underflow=1, and dout_valid (FWFT=0) stays 0 that cycle.
5. Pointer wrap:
   - Stimulus: stream 40 incrementing words at 1 write + 1 read per cycle, holding occupancy at 3.
   - Response: output sequence is identical to input; no flag errors.
6. Flush mid-stream:
   - Stimulus: with count=5 and overflow=1, assert clr together with wr_en.
   - Response: count=0, empty=1, overflow=0, and the write is ignored.
   - Then assert rst asynchronously mid-write.
   - Response: outputs take their reset values before the next edge.

Source files
------------

// File: rtl/dct_pkg.sv
// Shared constants and sizing helpers for the DCT datapath buffers.
package dct_pkg;

    localparam int DCT_COEF_W     = 36;
    localparam int DCT_FIFO_DEPTH = 8;

    // Address width for a DEPTH-entry array; never narrower than one bit.
    function automatic int dct_ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    // Occupancy counter width: must represent 0..DEPTH inclusive.
    function automatic int dct_cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/dct_stream_fifo_if.sv
// Handshake, data and status bundle between a DCT stage and its coefficient FIFO.
interface dct_stream_fifo_if
    import dct_pkg::*;
#(
    parameter int WIDTH = DCT_COEF_W,
    parameter int DEPTH = DCT_FIFO_DEPTH
);
    logic                        clr;
    logic                        wr_en;
    logic [WIDTH-1:0]            din;
    logic                        rd_en;
    logic [WIDTH-1:0]            dout;
    logic                        dout_valid;
    logic                        full;
    logic                        empty;
    logic                        almost_full;
    logic                        almost_empty;
    logic [dct_cnt_w(DEPTH)-1:0] count;
    logic                        overflow;
    logic                        underflow;

    modport master (
        output clr, wr_en, din, rd_en,
        input  dout, dout_valid, full, empty, almost_full, almost_empty,
               count, overflow, underflow
    );

    modport slave (
        input  clr, wr_en, din, rd_en,
        output dout, dout_valid, full, empty, almost_full, almost_empty,
               count, overflow, underflow
    );
endinterface

// File: rtl/dct_fifo_ram.sv
// DEPTH x WIDTH storage: synchronous write, asynchronous read, no reset on the array.
module dct_fifo_ram
    import dct_pkg::*;
#(
    parameter int WIDTH = DCT_COEF_W,
    parameter int DEPTH = DCT_FIFO_DEPTH
) (
    input  logic                        clk,
    input  logic                        we,
    input  logic [dct_ptr_w(DEPTH)-1:0] waddr,
    input  logic [WIDTH-1:0]            wdata,
    input  logic [dct_ptr_w(DEPTH)-1:0] raddr,
    output logic [WIDTH-1:0]            rdata
);
    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];
endmodule

// File: rtl/dct_stream_fifo.sv
// Coefficient FIFO between DCT row/transpose/column stages: occupancy flags,
// sticky error flags, synchronous flush, registered or fall-through read.
module dct_stream_fifo
    import dct_pkg::*;
#(
    parameter int WIDTH    = DCT_COEF_W,
    parameter int DEPTH    = DCT_FIFO_DEPTH,
    parameter int AF_LEVEL = DEPTH - 1,
    parameter int AE_LEVEL = 1,
    parameter bit FWFT     = 1'b0
) (
    input logic               clk,
    input logic               rst,
    dct_stream_fifo_if.slave  bus
);
    localparam int AW = dct_ptr_w(DEPTH);
    localparam int CW = dct_cnt_w(DEPTH);

    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic [CW-1:0]    count_next;
    logic             wr_acc;
    logic             rd_acc;
    logic             full_q;
    logic             empty_q;
    logic             af_q;
    logic             ae_q;
    logic             ovf_q;
    logic             unf_q;
    logic [WIDTH-1:0] ram_rdata;

    // A full FIFO still takes a write when the head leaves in the same cycle.
    assign rd_acc = bus.rd_en & ~empty_q;
    assign wr_acc = bus.wr_en & (~full_q | rd_acc);

    always_comb begin
        count_next = count;
        case ({wr_acc, rd_acc})
            2'b10:   count_next = count + CW'(1);
            2'b01:   count_next = count - CW'(1);
            default: count_next = count;
        endcase
    end

    dct_fifo_ram #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_ram (
        .clk   (clk),
        .we    (wr_acc & ~bus.clr),
        .waddr (wr_ptr),
        .wdata (bus.din),
        .raddr (rd_ptr),
        .rdata (ram_rdata)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
            af_q    <= 1'b0;
            ae_q    <= 1'b1;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else if (bus.clr) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
            af_q    <= 1'b0;
            ae_q    <= 1'b1;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (rd_acc) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count   <= count_next;
            // Flags come from count_next so they never lag count by a cycle.
            full_q  <= (count_next == CW'(DEPTH));
            empty_q <= (count_next == '0);
            af_q    <= (count_next >= CW'(AF_LEVEL));
            ae_q    <= (count_next <= CW'(AE_LEVEL));
            ovf_q   <= ovf_q | (bus.wr_en & ~wr_acc);
            unf_q   <= unf_q | (bus.rd_en & ~rd_acc);
        end
    end

    generate
        if (FWFT) begin : g_fwft
            assign bus.dout       = ram_rdata;
            assign bus.dout_valid = ~empty_q;
        end else begin : g_reg_read
            logic [WIDTH-1:0] dout_q;
            logic             dout_valid_q;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    dout_q       <= '0;
                    dout_valid_q <= 1'b0;
                end else if (bus.clr) begin
                    dout_valid_q <= 1'b0;
                end else begin
                    dout_valid_q <= rd_acc;
                    if (rd_acc) begin
                        dout_q <= ram_rdata;
                    end
                end
            end

            assign bus.dout       = dout_q;
            assign bus.dout_valid = dout_valid_q;
        end
    endgenerate

    assign bus.count        = count;
    assign bus.full         = full_q;
    assign bus.empty        = empty_q;
    assign bus.almost_full  = af_q;
    assign bus.almost_empty = ae_q;
    assign bus.overflow     = ovf_q;
    assign bus.underflow    = unf_q;
endmodule

// File: tb/tb_dct_stream_fifo.sv
// Drives a registered-read and a fall-through FIFO with identical stimulus;
// a reference model predicts flags, and a scoreboard queue per DUT checks read data.
module tb_dct_stream_fifo;
    import dct_pkg::*;

    localparam int W = 36;
    localparam int D = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         clr = 1'b0;
    logic         wr_en = 1'b0;
    logic         rd_en = 1'b0;
    logic [W-1:0] din = '0;

    int checks = 0;
    int errors = 0;

    int mcount = 0;
    bit m_ovf = 1'b0;
    bit m_unf = 1'b0;
    bit m_dv0 = 1'b0;
    logic [W-1:0] q0[$];
    logic [W-1:0] q1[$];

    dct_stream_fifo_if #(.WIDTH(W), .DEPTH(D)) if0 ();
    dct_stream_fifo_if #(.WIDTH(W), .DEPTH(D)) if1 ();

    assign if0.clr = clr;
    assign if0.wr_en = wr_en;
    assign if0.din = din;
    assign if0.rd_en = rd_en;
    assign if1.clr = clr;
    assign if1.wr_en = wr_en;
    assign if1.din = din;
    assign if1.rd_en = rd_en;

    dct_stream_fifo #(.WIDTH(W), .DEPTH(D), .FWFT(1'b0)) u_reg (.clk(clk), .rst(rst), .bus(if0));
    dct_stream_fifo #(.WIDTH(W), .DEPTH(D), .FWFT(1'b1)) u_fwft (.clk(clk), .rst(rst), .bus(if1));

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard: registered mode pops on dout_valid, fall-through mode pops on an accepted head.
    always @(negedge clk) begin
        if (!rst) begin
            if (if0.dout_valid) begin
                if (q0.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL reg_spurious: got dout %0h expected no output", if0.dout);
                end else begin
                    chk("reg_dout", 64'(if0.dout), 64'(q0.pop_front()));
                end
            end
            if (if1.dout_valid && rd_en && !clr) begin
                if (q1.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL fwft_spurious: got dout %0h expected no output", if1.dout);
                end else begin
                    chk("fwft_dout", 64'(if1.dout), 64'(q1.pop_front()));
                end
            end
        end
    end

    task automatic check_flags();
        chk("reg_count", 64'(if0.count), 64'(mcount));
        chk("reg_full", 64'(if0.full), 64'(mcount == D));
        chk("reg_empty", 64'(if0.empty), 64'(mcount == 0));
        chk("reg_afull", 64'(if0.almost_full), 64'(mcount >= D - 1));
        chk("reg_aempty", 64'(if0.almost_empty), 64'(mcount <= 1));
        chk("reg_ovf", 64'(if0.overflow), 64'(m_ovf));
        chk("reg_unf", 64'(if0.underflow), 64'(m_unf));
        chk("reg_dvalid", 64'(if0.dout_valid), 64'(m_dv0));
        chk("fwft_count", 64'(if1.count), 64'(mcount));
        chk("fwft_full", 64'(if1.full), 64'(mcount == D));
        chk("fwft_empty", 64'(if1.empty), 64'(mcount == 0));
        chk("fwft_afull", 64'(if1.almost_full), 64'(mcount >= D - 1));
        chk("fwft_aempty", 64'(if1.almost_empty), 64'(mcount <= 1));
        chk("fwft_ovf", 64'(if1.overflow), 64'(m_ovf));
        chk("fwft_unf", 64'(if1.underflow), 64'(m_unf));
        chk("fwft_dvalid", 64'(if1.dout_valid), 64'(mcount != 0));
    endtask

    // Called one time unit after a rising edge; applies inputs for the next edge.
    task automatic cycle(input bit w, input logic [W-1:0] d, input bit r, input bit c);
        bit wacc;
        bit racc;
        wr_en = w;
        din   = d;
        rd_en = r;
        clr   = c;
        racc = r && (mcount > 0);
        wacc = w && ((mcount < D) || racc);
        if (c) begin
            mcount = 0;
            m_ovf  = 1'b0;
            m_unf  = 1'b0;
            m_dv0  = 1'b0;
        end else begin
            if (wacc) begin
                q0.push_back(d);
                q1.push_back(d);
            end
            mcount = mcount + int'(wacc) - int'(racc);
            m_ovf  = m_ovf | (w && !wacc);
            m_unf  = m_unf | (r && !racc);
            m_dv0  = racc;
        end
        @(posedge clk);
        #1;
        if (c) begin
            q0.delete();
            q1.delete();
        end
        check_flags();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, '0, 1'b0, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // 1: reset then idle
        repeat (2) @(posedge clk);
        #1;
        chk("rst_empty", 64'(if0.empty), 64'd1);
        chk("rst_dout", 64'(if0.dout), 64'd0);
        rst = 1'b0;
        idle(2);

        // 2: fill to full plus one, then drain and underflow
        for (int i = 1; i <= 9; i++) begin
            cycle(1'b1, W'(i), 1'b0, 1'b0);
            if (i == 7) chk("s2_afull_at7", 64'(if1.almost_full), 64'd1);
            if (i == 8) chk("s2_full_at8", 64'(if0.full), 64'd1);
        end
        chk("s2_ovf", 64'(if0.overflow), 64'd1);
        chk("s2_count8", 64'(if1.count), 64'd8);
        for (int i = 0; i < 8; i++) cycle(1'b0, '0, 1'b1, 1'b0);
        cycle(1'b0, '0, 1'b1, 1'b0);
        chk("s2_unf", 64'(if0.underflow), 64'd1);
        idle(1);

        // 3: simultaneous read and write at full
        cycle(1'b0, '0, 1'b0, 1'b1);
        for (int i = 0; i < 8; i++) cycle(1'b1, W'(36'h10 + i), 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) cycle(1'b1, W'(36'h20 + i), 1'b1, 1'b0);
        chk("s3_count8", 64'(if0.count), 64'd8);
        chk("s3_no_ovf", 64'(if1.overflow), 64'd0);
        for (int i = 0; i < 8; i++) cycle(1'b0, '0, 1'b1, 1'b0);
        idle(1);

        // 4: simultaneous read and write at empty
        cycle(1'b0, '0, 1'b0, 1'b1);
        cycle(1'b1, 36'h30, 1'b1, 1'b0);
        chk("s4_count1", 64'(if0.count), 64'd1);
        chk("s4_unf", 64'(if1.underflow), 64'd1);
        chk("s4_no_dvalid", 64'(if0.dout_valid), 64'd0);
        chk("s4_fwft_head", 64'(if1.dout), 64'h30);
        cycle(1'b0, '0, 1'b1, 1'b0);
        idle(1);

        // 5: pointer wrap at occupancy 3
        cycle(1'b0, '0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) cycle(1'b1, W'(36'h100 + i), 1'b0, 1'b0);
        for (int i = 3; i < 43; i++) cycle(1'b1, W'(36'h100 + i), 1'b1, 1'b0);
        chk("s5_count3", 64'(if0.count), 64'd3);
        for (int i = 0; i < 3; i++) cycle(1'b0, '0, 1'b1, 1'b0);
        idle(1);

        // 6: flush with a concurrent write, then asynchronous reset mid-write
        cycle(1'b0, '0, 1'b0, 1'b1);
        for (int i = 0; i < 9; i++) cycle(1'b1, W'(36'h40 + i), 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) cycle(1'b0, '0, 1'b1, 1'b0);
        chk("s6_count5", 64'(if0.count), 64'd5);
        chk("s6_ovf_set", 64'(if1.overflow), 64'd1);
        cycle(1'b1, 36'h49, 1'b0, 1'b1);
        chk("s6_clr_count", 64'(if1.count), 64'd0);
        chk("s6_clr_ovf", 64'(if0.overflow), 64'd0);
        cycle(1'b1, 36'h50, 1'b0, 1'b0);
        cycle(1'b1, 36'h51, 1'b1, 1'b0);
        wr_en = 1'b1;
        din   = 36'h52;
        rd_en = 1'b1;
        clr   = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("s6_rst_count", 64'(if0.count), 64'd0);
        chk("s6_rst_empty", 64'(if1.empty), 64'd1);
        chk("s6_rst_aempty", 64'(if0.almost_empty), 64'd1);
        chk("s6_rst_dout", 64'(if0.dout), 64'd0);
        chk("s6_rst_dvalid0", 64'(if0.dout_valid), 64'd0);
        chk("s6_rst_dvalid1", 64'(if1.dout_valid), 64'd0);
        chk("s6_rst_unf", 64'(if1.underflow), 64'd0);
        wr_en = 1'b0;
        rd_en = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        mcount = 0;
        m_ovf  = 1'b0;
        m_unf  = 1'b0;
        m_dv0  = 1'b0;
        q0.delete();
        q1.delete();
        cycle(1'b1, 36'h60, 1'b0, 1'b0);
        chk("s6_post_rst_head", 64'(if1.dout), 64'h60);
        cycle(1'b0, '0, 1'b1, 1'b0);
        idle(2);

        chk("reg_drained", 64'(q0.size()), 64'd0);
        chk("fwft_drained", 64'(q1.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
